// File: rtl/conv_tile_scheduler_pkg.sv
// Shared types and helpers for the convolution tile scheduler.
package conv_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    READ,
    DRAIN,
    DONE
  } sched_state_e;

  localparam int unsigned DEF_COLS  = 256;
  localparam int unsigned DEF_ROWS  = 32;
  localparam int unsigned PAD_W     = DEF_COLS + 2;
  localparam int unsigned MAX_TILES = 64;

  // Callers size-cast the result down to their own tile count.
  function automatic logic [MAX_TILES-1:0] onehot(input int unsigned idx);
    return MAX_TILES'(1) << idx;
  endfunction

endpackage

// File: rtl/conv_tile_scheduler_if.sv
// Frame control and tile strobe bundle between the scheduler and its surroundings.
interface conv_tile_scheduler_if #(
  parameter int unsigned NUM_TILES = 8
);
  localparam int unsigned TW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

  logic                 start;
  logic                 abort;
  logic                 stall;
  logic                 mem_clr;
  logic [NUM_TILES-1:0] tile_rd;
  logic [NUM_TILES-1:0] tile_wr;
  logic [TW-1:0]        cur_tile;
  logic                 busy;
  logic                 done;

  modport master (
    output start, abort, stall,
    input  mem_clr, tile_rd, tile_wr, cur_tile, busy, done
  );

  modport slave (
    input  start, abort, stall,
    output mem_clr, tile_rd, tile_wr, cur_tile, busy, done
  );
endinterface

// File: rtl/conv_tile_scheduler_delay_line.sv
// Valid+payload shift register tracking reads through the filter pipeline.
module sched_delay_line #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             pending
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= flush ? 1'b0 : in_valid;
      data_q[0]  <= in_data;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        valid_q[i] <= flush ? 1'b0 : valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

  // Entries still upstream of the output stage; the output stage itself is being written now.
  always_comb begin
    pending = 1'b0;
    for (int unsigned i = 0; i + 1 < DEPTH; i++) pending = pending | valid_q[i];
  end

endmodule

// File: rtl/conv_tile_scheduler.sv
// Frame sequencer: clears tiles, streams window reads tile by tile, returns filter writes.
module conv_tile_scheduler
  import conv_sched_pkg::*;
#(
  parameter int unsigned NUM_TILES = 8,
  parameter int unsigned COLS      = DEF_COLS,
  parameter int unsigned ROWS      = DEF_ROWS,
  parameter int unsigned PIPE_LAT  = 3
) (
  input logic                   clk,
  input logic                   rst,
  conv_tile_scheduler_if.slave  bus
);

  localparam int unsigned TW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [TW-1:0] TILE_LAST = TW'(NUM_TILES - 1);

  sched_state_e  state, state_nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [TW-1:0] tile;
  logic          rd_issue, last_win;
  logic          wr_valid, dly_pending;
  logic [TW-1:0] wr_tile;

  assign rd_issue = (state == READ) && !bus.stall && !bus.abort;
  assign last_win = (col == COL_LAST) && (row == ROW_LAST) && (tile == TILE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (bus.start) state_nxt = CLEAR;
        CLEAR: state_nxt = READ;
        READ:  if (rd_issue && last_win) state_nxt = DRAIN;
        DRAIN: if (!dly_pending) state_nxt = DONE;
        DONE:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Tile index is held on the final window so cur_tile stays on the last tile while draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col  <= '0;
      row  <= '0;
      tile <= '0;
    end else if (bus.abort || state == CLEAR) begin
      col  <= '0;
      row  <= '0;
      tile <= '0;
    end else if (rd_issue) begin
      if (col == COL_LAST) begin
        col <= '0;
        if (row == ROW_LAST) begin
          row <= '0;
          if (tile != TILE_LAST) tile <= tile + 1'b1;
        end else begin
          row <= row + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  sched_delay_line #(
    .DEPTH(PIPE_LAT),
    .WIDTH(TW)
  ) u_delay_line (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.abort),
    .in_valid (rd_issue),
    .in_data  (tile),
    .out_valid(wr_valid),
    .out_data (wr_tile),
    .pending  (dly_pending)
  );

  always_comb begin
    bus.mem_clr  = (state == CLEAR);
    bus.busy     = (state != IDLE);
    bus.done     = (state == DONE) && !bus.abort;
    bus.cur_tile = (state == READ || state == DRAIN) ? tile : '0;
    bus.tile_rd  = rd_issue ? NUM_TILES'(onehot(32'(tile))) : '0;
    bus.tile_wr  = wr_valid ? NUM_TILES'(onehot(32'(wr_tile))) : '0;
  end

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Directed bench for conv_tile_scheduler on a 2-tile, 4x2-window, 3-stage configuration.
module tb_conv_tile_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  conv_tile_scheduler_if #(.NUM_TILES(2)) bus ();

  conv_tile_scheduler #(
    .NUM_TILES(2),
    .COLS     (4),
    .ROWS     (2),
    .PIPE_LAT (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe counters and write-lag tracking, sampled mid-cycle.
  int         rd_cnt [2];
  int         wr_cnt [2];
  int         done_cnt = 0;
  int         clr_cnt  = 0;
  logic [1:0] hist [3];

  initial begin
    for (int i = 0; i < 2; i++) begin rd_cnt[i] = 0; wr_cnt[i] = 0; end
    for (int i = 0; i < 3; i++) hist[i] = 2'b00;
  end

  always @(negedge clk) begin
    logic [1:0] exp_wr;
    exp_wr = rst ? 2'b00 : hist[2];
    chk("wr_lag", 32'(bus.tile_wr), 32'(exp_wr));
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (bus.tile_rd[i]) rd_cnt[i]++;
        if (bus.tile_wr[i]) wr_cnt[i]++;
      end
      if (bus.done)    done_cnt++;
      if (bus.mem_clr) clr_cnt++;
    end
    if (rst || bus.abort) begin
      for (int i = 0; i < 3; i++) hist[i] = 2'b00;
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = bus.tile_rd;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      tick();
      if (bus.done) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'(1));
    tick();
  endtask

  initial begin
    int rd0, rd1, wr0, wr1, dn, cl;
    logic [1:0] exp_rd, exp_wr;

    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.stall = 1'b0;

    // Reset values
    #2;
    chk("rst_busy",    32'(bus.busy),     32'(0));
    chk("rst_mem_clr", 32'(bus.mem_clr),  32'(0));
    chk("rst_tile_rd", 32'(bus.tile_rd),  32'(0));
    chk("rst_tile_wr", 32'(bus.tile_wr),  32'(0));
    chk("rst_done",    32'(bus.done),     32'(0));
    chk("rst_cur",     32'(bus.cur_tile), 32'(0));
    tick(); tick();
    rst = 1'b0;
    tick();

    // Unstalled frame: clear, 16 reads, 3 drain cycles, done
    dn = done_cnt; cl = clr_cnt;
    bus.start = 1'b1; #1;
    chk("idle_busy", 32'(bus.busy), 32'(0));
    tick(); bus.start = 1'b0; #1;
    chk("clr_mem_clr", 32'(bus.mem_clr), 32'(1));
    chk("clr_busy",    32'(bus.busy),    32'(1));
    chk("clr_tile_rd", 32'(bus.tile_rd), 32'(0));
    for (int i = 0; i < 19; i++) begin
      tick(); #1;
      exp_rd = (i >= 16) ? 2'b00 : (i < 8) ? 2'b01 : 2'b10;
      exp_wr = (i < 3) ? 2'b00 : (i - 3 < 8) ? 2'b01 : 2'b10;
      chk("f1_tile_rd", 32'(bus.tile_rd), 32'(exp_rd));
      chk("f1_tile_wr", 32'(bus.tile_wr), 32'(exp_wr));
      chk("f1_mem_clr", 32'(bus.mem_clr), 32'(0));
      chk("f1_done",    32'(bus.done),    32'(0));
      if (i < 16) chk("f1_cur_tile", 32'(bus.cur_tile), 32'(i / 8));
    end
    tick(); #1;
    chk("f1_done_pulse", 32'(bus.done),    32'(1));
    chk("f1_done_wr",    32'(bus.tile_wr), 32'(0));
    tick(); #1;
    chk("f1_idle_busy", 32'(bus.busy), 32'(0));
    chk("f1_idle_done", 32'(bus.done), 32'(0));
    chk("f1_rd0", 32'(rd_cnt[0]), 32'(8));
    chk("f1_rd1", 32'(rd_cnt[1]), 32'(8));
    chk("f1_wr0", 32'(wr_cnt[0]), 32'(8));
    chk("f1_wr1", 32'(wr_cnt[1]), 32'(8));
    chk("f1_done_cnt", 32'(done_cnt - dn), 32'(1));
    chk("f1_clr_cnt",  32'(clr_cnt - cl),  32'(1));

    // Stall on every other READ cycle
    rd0 = rd_cnt[0]; rd1 = rd_cnt[1]; wr0 = wr_cnt[0]; wr1 = wr_cnt[1];
    bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      tick();
      bus.stall = (k % 2 == 1);
      #1;
      exp_rd = (k % 2 == 1) ? 2'b00 : ((k / 2) < 8) ? 2'b01 : 2'b10;
      chk("st_tile_rd", 32'(bus.tile_rd), 32'(exp_rd));
      if (k < 31) chk("st_cur_tile", 32'(bus.cur_tile), 32'(((k + 1) / 2) / 8));
    end
    bus.stall = 1'b0;
    wait_done("st_done_seen");
    chk("st_rd0", 32'(rd_cnt[0] - rd0), 32'(8));
    chk("st_rd1", 32'(rd_cnt[1] - rd1), 32'(8));
    chk("st_wr0", 32'(wr_cnt[0] - wr0), 32'(8));
    chk("st_wr1", 32'(wr_cnt[1] - wr1), 32'(8));

    // Abort on tile 1, column 2
    dn = done_cnt;
    bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    tick();
    bus.abort = 1'b1; #1;
    chk("ab_cur_tile", 32'(bus.cur_tile), 32'(1));
    chk("ab_tile_rd",  32'(bus.tile_rd),  32'(0));
    chk("ab_busy",     32'(bus.busy),     32'(1));
    tick(); bus.abort = 1'b0; #1;
    chk("ab_busy_after", 32'(bus.busy),    32'(0));
    chk("ab_flush_wr",   32'(bus.tile_wr), 32'(0));
    rd0 = rd_cnt[0] + rd_cnt[1]; wr0 = wr_cnt[0] + wr_cnt[1];
    for (int i = 0; i < 6; i++) tick();
    chk("ab_no_rd",   32'(rd_cnt[0] + rd_cnt[1] - rd0), 32'(0));
    chk("ab_no_wr",   32'(wr_cnt[0] + wr_cnt[1] - wr0), 32'(0));
    chk("ab_no_done", 32'(done_cnt - dn), 32'(0));
    bus.start = 1'b1;
    tick(); bus.start = 1'b0; #1;
    chk("ab_restart_clr", 32'(bus.mem_clr), 32'(1));
    tick(); #1;
    chk("ab_restart_rd",  32'(bus.tile_rd),  32'(1));
    chk("ab_restart_cur", 32'(bus.cur_tile), 32'(0));
    wait_done("ab_restart_done");

    // Start held high through a whole frame
    cl = clr_cnt;
    bus.start = 1'b1;
    tick(); #1;
    chk("hold_clr", 32'(bus.mem_clr), 32'(1));
    for (int k = 1; k <= 20; k++) begin
      tick(); #1;
      chk("hold_no_clr", 32'(bus.mem_clr), 32'(0));
    end
    chk("hold_done", 32'(bus.done), 32'(1));
    tick(); #1;
    chk("hold_idle", 32'(bus.busy), 32'(0));
    tick(); #1;
    chk("hold_reclr", 32'(bus.mem_clr), 32'(1));
    chk("hold_clr_cnt", 32'(clr_cnt - cl), 32'(1));
    bus.start = 1'b0;
    bus.abort = 1'b1;
    tick(); bus.abort = 1'b0;
    tick();

    // Asynchronous reset mid-READ
    bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    tick(); tick(); tick();
    tick();
    chk("rr_pre_rd", 32'(bus.tile_rd), 32'(1));
    rst = 1'b1; #1;
    chk("rr_busy",    32'(bus.busy),     32'(0));
    chk("rr_tile_rd", 32'(bus.tile_rd),  32'(0));
    chk("rr_tile_wr", 32'(bus.tile_wr),  32'(0));
    chk("rr_cur",     32'(bus.cur_tile), 32'(0));
    chk("rr_mem_clr", 32'(bus.mem_clr),  32'(0));
    chk("rr_done",    32'(bus.done),     32'(0));
    tick(); tick();
    rst = 1'b0;
    tick(); #1;
    chk("rr_idle_busy", 32'(bus.busy),     32'(0));
    chk("rr_idle_cur",  32'(bus.cur_tile), 32'(0));
    tick(); #1;
    chk("rr_stays_idle", 32'(bus.busy), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
